// File: rtl/fread_loader_pkg.sv
// Shared types and constants for the fread RAM loader: FSM encoding, SPRAM geometry and
// the elaboration-time configuration check.
package fread_loader_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StRecv,
    StDone
  } state_e;

  localparam int unsigned SPRAM_WORDS = 16384;
  localparam int unsigned SPRAM_AW    = 14;

  // Chunks must be even so every chunk ends on a completed 16-bit word.
  function automatic bit cfg_ok(int unsigned chunk_len, int unsigned total_len);
    return (chunk_len >= 2) && (chunk_len <= 2048) && (chunk_len % 2 == 0) &&
           (total_len != 0) && (total_len <= 2 * SPRAM_WORDS) &&
           (total_len % chunk_len == 0);
  endfunction

endpackage

// File: rtl/fread_ram_loader_if.sv
// fread request/response channel between the loader (master) and spi_dev_fread (slave).
interface fread_ram_loader_if;

  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_offset;
  logic [10:0] req_len;
  logic [7:0]  resp_data;
  logic        resp_valid;

  modport master (
    output req_valid,
    output req_offset,
    output req_len,
    input  req_ready,
    input  resp_data,
    input  resp_valid
  );

  modport slave (
    input  req_valid,
    input  req_offset,
    input  req_len,
    output req_ready,
    output resp_data,
    output resp_valid
  );

endinterface

// File: rtl/spram_16k.sv
// 16K x 16 single-port RAM with a registered read port; written in a form that maps onto one
// SB_SPRAM256KA with all four nibble write enables tied high.
module spram_16k
  import fread_loader_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ce_i,
  input  logic                we_i,
  input  logic [SPRAM_AW-1:0] addr_i,
  input  logic [15:0]         wdata_i,
  output logic [15:0]         rdata_o
);

  logic [15:0] mem_q [SPRAM_WORDS];
  logic [15:0] rdata_q;

  always_ff @(posedge clk) begin
    if (ce_i && we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Output only updates on a read, so it holds through write cycles and deselected cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (ce_i && !we_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fread_ram_loader.sv
// Fetches a file in fixed-size fread chunks and packs the byte stream little-endian into SPRAM.
// Define FREAD_LOADER_RETRY_EN to add a per-chunk idle timeout that re-requests the chunk.
module fread_ram_loader
  import fread_loader_pkg::*;
#(
  parameter int unsigned CHUNK_LEN   = 2048,
  parameter int unsigned TOTAL_LEN   = 32768,
  parameter int unsigned TIMEOUT_CYC = 1048576
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  fread_ram_loader_if.master  fread,
  input  logic [SPRAM_AW-1:0] rd_addr_i,
  output logic [15:0]         rd_data_o,
  output logic                busy_o,
  output logic                done_o,
  output logic [7:0]          retry_cnt_o
);

  if (!cfg_ok(CHUNK_LEN, TOTAL_LEN) || (TIMEOUT_CYC == 0)) begin : g_cfg_err
    $error("fread_ram_loader: invalid CHUNK_LEN/TOTAL_LEN/TIMEOUT_CYC combination");
  end

  state_e              state_q, state_d;
  logic [31:0]         offset_q, offset_d;
  logic [10:0]         cnt_q, cnt_d;
  logic [7:0]          low_q, low_d;
  logic                wr_en_q, wr_en_d;
  logic [SPRAM_AW-1:0] wr_addr_q, wr_addr_d;
  logic [15:0]         wr_data_q, wr_data_d;

  logic [31:0]         next_off;
  logic                last_byte;

  assign next_off  = offset_q + 32'(CHUNK_LEN);
  assign last_byte = (cnt_q == 11'(CHUNK_LEN - 1));

`ifdef FREAD_LOADER_RETRY_EN
  logic [31:0] timer_q, timer_d;
  logic [7:0]  retry_q, retry_d;
`endif

  always_comb begin
    state_d   = state_q;
    offset_d  = offset_q;
    cnt_d     = cnt_q;
    low_d     = low_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
`ifdef FREAD_LOADER_RETRY_EN
    timer_d   = timer_q;
    retry_d   = retry_q;
`endif

    case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          state_d  = StReq;
          offset_d = '0;
          cnt_d    = '0;
`ifdef FREAD_LOADER_RETRY_EN
          retry_d  = '0;
`endif
        end
      end

      StReq: begin
        if (fread.req_ready) begin
          state_d = StRecv;
`ifdef FREAD_LOADER_RETRY_EN
          timer_d = '0;
`endif
        end
      end

      StRecv: begin
        if (fread.resp_valid) begin
          cnt_d = cnt_q + 11'd1;
          if (!cnt_q[0]) begin
            low_d = fread.resp_data;
          end else begin
            // Offsets are always even, so the word address splits cleanly.
            wr_en_d   = 1'b1;
            wr_addr_d = offset_q[14:1] + SPRAM_AW'(cnt_q[10:1]);
            wr_data_d = {fread.resp_data, low_q};
          end
          if (last_byte) begin
            cnt_d    = '0;
            offset_d = next_off;
            state_d  = (next_off == 32'(TOTAL_LEN)) ? StDone : StReq;
          end
        end
`ifdef FREAD_LOADER_RETRY_EN
        if (fread.resp_valid) begin
          timer_d = '0;
        end else if (timer_q == 32'(TIMEOUT_CYC - 1)) begin
          timer_d = '0;
          cnt_d   = '0;
          state_d = StReq;
          if (retry_q != 8'hFF) begin
            retry_d = retry_q + 8'd1;
          end
        end else begin
          timer_d = timer_q + 32'd1;
        end
`endif
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      offset_q  <= '0;
      cnt_q     <= '0;
      low_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      offset_q  <= offset_d;
      cnt_q     <= cnt_d;
      low_q     <= low_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

`ifdef FREAD_LOADER_RETRY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
      retry_q <= '0;
    end else begin
      timer_q <= timer_d;
      retry_q <= retry_d;
    end
  end

  assign retry_cnt_o = retry_q;
`else
  assign retry_cnt_o = '0;
`endif

  assign fread.req_valid  = (state_q == StReq);
  assign fread.req_offset = offset_q;
  assign fread.req_len    = 11'(CHUNK_LEN - 1);
  assign busy_o           = (state_q == StReq) || (state_q == StRecv);
  assign done_o           = (state_q == StDone);

  // The last word of an image is written in the first DONE cycle, so a pending write still
  // owns the port even after busy has dropped.
  logic                ram_wr_sel;
  logic                ram_ce;
  logic [SPRAM_AW-1:0] ram_addr;

  assign ram_wr_sel = busy_o || wr_en_q;
  assign ram_ce     = wr_en_q || !ram_wr_sel;
  assign ram_addr   = ram_wr_sel ? wr_addr_q : rd_addr_i;

  spram_16k u_spram (
    .clk     (clk),
    .rst_n   (rst_n),
    .ce_i    (ram_ce),
    .we_i    (wr_en_q),
    .addr_i  (ram_addr),
    .wdata_i (wr_data_q),
    .rdata_o (rd_data_o)
  );

endmodule

// File: tb/tb_fread_ram_loader.sv
// Randomised scoreboard bench for fread_ram_loader: a file-server model answers requests,
// monitors check request offsets and read-port data against queued expectations.
module tb_fread_ram_loader;
  import fread_loader_pkg::*;

  localparam int unsigned CHUNK      = 512;
  localparam int unsigned TOTAL      = 8192;
  localparam int unsigned NCHUNK     = TOTAL / CHUNK;
  localparam int unsigned NWORDS     = TOTAL / 2;
  localparam int unsigned TMO        = 64;
  localparam int unsigned DROP_CHUNK = 3;
  localparam int unsigned DROP_AFTER = 100;
`ifdef FREAD_LOADER_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [13:0] rd_addr = '0;
  logic [15:0] rd_data;
  logic        busy;
  logic        done;
  logic [7:0]  retry_cnt;

  fread_ram_loader_if bus ();

  fread_ram_loader #(
    .CHUNK_LEN   (CHUNK),
    .TOTAL_LEN   (TOTAL),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start),
    .fread       (bus),
    .rd_addr_i   (rd_addr),
    .rd_data_o   (rd_data),
    .busy_o      (busy),
    .done_o      (done),
    .retry_cnt_o (retry_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // File content model: byte b of the file is b[7:0] xor a per-load key.
  logic [7:0]  seed = 8'h00;
  bit          drop_armed = 1'b0;
  int unsigned exp_off_q[$];
  logic [15:0] rd_exp_q[$];
  logic [15:0] last_rd_exp = 16'h0000;
  int          req_seen = 0;

  function automatic logic [7:0] file_byte(logic [7:0] s, int unsigned b);
    return b[7:0] ^ s;
  endfunction

  function automatic logic [15:0] file_word(logic [7:0] s, int unsigned w);
    return {file_byte(s, 2 * w + 1), file_byte(s, 2 * w)};
  endfunction

  // File server: 3 cycles of pending request, then accept, then stream the chunk with gaps.
  int          rsp_ph = 0;
  int          rsp_wc = 0;
  int unsigned rsp_idx = 0;
  int unsigned rsp_off = 0;

  initial begin
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_data  = 8'h00;
    forever begin
      @(negedge clk);
      bus.req_ready  = 1'b0;
      bus.resp_valid = 1'b0;
      bus.resp_data  = 8'($urandom);
      if (!rst_n) begin
        rsp_ph = 0;
      end else begin
        case (rsp_ph)
          0: if (bus.req_valid) begin
            rsp_ph = 1;
            rsp_wc = 0;
          end
          1: begin
            rsp_wc++;
            bus.resp_valid = ($urandom_range(0, 1) == 1);  // stray byte while pending
            if (rsp_wc == 3) begin
              bus.req_ready  = 1'b1;
              bus.resp_valid = 1'b1;  // stray byte in the accept cycle
              rsp_off        = bus.req_offset;
              rsp_idx        = 0;
              rsp_ph         = 2;
            end
          end
          default: begin
            if (drop_armed && rsp_off == DROP_CHUNK * CHUNK && rsp_idx == DROP_AFTER) begin
              drop_armed = 1'b0;
              rsp_ph     = 0;
            end else if ($urandom_range(0, 7) != 0) begin
              bus.resp_valid = 1'b1;
              bus.resp_data  = file_byte(seed, rsp_off + rsp_idx);
              rsp_idx++;
              if (rsp_idx == CHUNK) rsp_ph = 0;
            end
          end
        endcase
      end
    end
  end

  // Request monitor: each accepted handshake must match the next expected offset.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && bus.req_valid && bus.req_ready) begin
        req_seen++;
        check("req_len", 32'(bus.req_len), CHUNK - 1);
        if (exp_off_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL req_extra: got request at offset 0x%0h, expected none", bus.req_offset);
        end else begin
          check("req_offset", bus.req_offset, exp_off_q.pop_front());
        end
      end
    end
  end

  // Read monitor: one expected word per address presented on the previous cycle.
  logic [15:0] rd_exp_cur;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rd_exp_q.size() > 0) begin
        rd_exp_cur = rd_exp_q.pop_front();
        check("rd_data", 32'(rd_data), 32'(rd_exp_cur));
      end
    end
  end

  task automatic read_word(int unsigned a, logic [15:0] exp);
    @(negedge clk);
    rd_addr = 14'(a);
    rd_exp_q.push_back(exp);
    last_rd_exp = exp;
  endtask

  task automatic check_reset_values(string tag);
    check({tag, "_req_valid"}, 32'(bus.req_valid), 0);
    check({tag, "_req_offset"}, bus.req_offset, 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_rd_data"}, 32'(rd_data), 0);
    check({tag, "_retry_cnt"}, 32'(retry_cnt), 0);
  endtask

  task automatic expect_load(logic [7:0] s, bit drop);
    seed       = s;
    drop_armed = drop;
    req_seen   = 0;
    exp_off_q.delete();
    for (int c = 0; c < int'(NCHUNK); c++) begin
      exp_off_q.push_back(c * CHUNK);
      if (drop && c == int'(DROP_CHUNK)) exp_off_q.push_back(c * CHUNK);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_req_valid", 32'(bus.req_valid), 1);
    check("start_busy", 32'(busy), 1);
    check("start_done", 32'(done), 0);
    check("start_req_offset", bus.req_offset, 0);
  endtask

  // Waits for done within a cycle budget, optionally sprinkling start pulses into the load.
  task automatic finish_load(string name, bit noise, int exp_reqs, int exp_retry);
    int n = 0;
    while (!done && n < int'(4 * TOTAL + 4000)) begin
      start = noise && ($urandom_range(0, 255) == 0);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check({name, "_done"}, 32'(done), 1);
    check({name, "_busy"}, 32'(busy), 0);
    check({name, "_req_count"}, 32'(req_seen), 32'(exp_reqs));
    check({name, "_req_left"}, 32'(exp_off_q.size()), 0);
    check({name, "_retry_cnt"}, 32'(retry_cnt), 32'(exp_retry));
  endtask

  task automatic random_reads(int n);
    int unsigned a;
    read_word(0, file_word(seed, 0));
    read_word(NWORDS - 1, file_word(seed, NWORDS - 1));
    for (int i = 0; i < n; i++) begin
      a = $urandom_range(0, NWORDS - 1);
      read_word(a, file_word(seed, a));
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    check("reset_req_len", 32'(bus.req_len), CHUNK - 1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Load 1: incrementing pattern, stray bytes, stray starts, optional dropped chunk.
    expect_load(8'h00, RETRY);
    pulse_start();
    finish_load("load1", 1'b1, int'(NCHUNK) + int'(RETRY), int'(RETRY));
    for (int w = 0; w < int'(NWORDS); w++) read_word(w, file_word(seed, w));
    repeat (2) @(negedge clk);

    // Load 2: restart from DONE; read port holds while the writer owns the RAM.
    expect_load(8'h5A, 1'b0);
    pulse_start();
    for (int i = 0; i < 6; i++) read_word($urandom_range(0, NWORDS - 1), last_rd_exp);
    finish_load("load2", 1'b0, int'(NCHUNK), 0);
    random_reads(48);

    // Load 3: reset asserted part-way through chunk 5.
    expect_load(8'hC3, 1'b0);
    pulse_start();
    n = 0;
    while (req_seen < 6 && n < int'(4 * TOTAL)) begin
      @(negedge clk);
      n++;
    end
    check("mid_reset_reached_chunk5", 32'(req_seen), 6);
    repeat (40) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_values("mid_reset");
    exp_off_q.delete();
    @(negedge clk);
    check_reset_values("mid_reset_held");
    rst_n = 1'b1;
    @(negedge clk);

    // Load 4: fresh start after the reset must begin again at offset 0.
    expect_load(8'h3C, 1'b0);
    pulse_start();
    finish_load("load4", 1'b1, int'(NCHUNK), 0);
    random_reads(48);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fread_ram_loader.md
# fread_ram_loader

Streaming consumer placed directly downstream of `spi_dev_fread` (STREAM interface). It fetches a file from the ESP32 in fixed-size chunks by driving the fread request handshake with an incrementing offset. Received bytes are packed little-endian into 16-bit words and written into a single SPRAM bank. Once the whole image is resident, the block raises `done` and exposes a synchronous read port to the rest of the fabric.

## Interface
- `CHUNK_LEN`, 2048: bytes per fread request; even, 2..2048.
- `TOTAL_LEN`, 32768: image size in bytes; integer multiple of `CHUNK_LEN`, at most 32768.
- `TIMEOUT_CYC`, 1048576: idle-cycle limit per chunk; only used with retry compiled in.
- `clk  in  1`: system clock (30 MHz).
- `rst_n  in  1`: reset; asynchronous, active-low.
- `start  in  1`: one-cycle pulse that begins a load.
- `req_valid  out  1`: fread request valid.
- `req_ready  in  1`: fread request accepted.
- `req_offset  out  32`: byte offset of the current chunk.
- `req_len  out  11`: constant, equal to `CHUNK_LEN-1`.
- `resp_data  in  8`: streamed file byte.
- `resp_valid  in  1`: `resp_data` strobe.
- `rd_addr  in  14`: word address for post-load reads.
- `rd_data  out  16`: read data.
- `busy  out  1`: load in progress.
- `done  out  1`: image fully loaded.
- `retry_cnt  out  8`: saturating count of chunk retries.

## Operation
- FSM states: IDLE, REQ, RECV, DONE. Reset state is IDLE.
- IDLE: on `start`, clear the offset, byte counter and `retry_cnt`, then go to REQ.
- REQ: assert `req_valid` and hold `req_offset` stable until the cycle in which `req_valid` and `req_ready` are both high. Then go to RECV.
- RECV, byte handling:
  - Each `resp_valid` byte increments the in-chunk byte counter (11 bits).
  - An even-numbered byte is latched into the low half of the staging word.
  - An odd-numbered byte completes the word: write `{byte, low}` to word address `(req_offset + count) >> 1`.
- RECV, end of chunk: when the chunk's last byte arrives, advance the offset by `CHUNK_LEN`.
  - If the new offset equals `TOTAL_LEN`, go to DONE.
  - Otherwise go to REQ.
- DONE: `done` is high. Reads are serviced. A new `start` pulse re-enters the load sequence exactly as from IDLE; `done` drops in the cycle the FSM leaves DONE.
- Outside RECV, `resp_valid` is ignored. This discards stray or late bytes.
- `start` is ignored while `busy`.
- `busy` is high in REQ and RECV.
- While `busy`, the SPRAM port belongs to the writer. `rd_addr` is ignored and `rd_data` holds its last value.
- Width rules:
  - The offset adder is 32-bit; no wrap can occur because `TOTAL_LEN` ≤ 32768.
  - Word address is taken from bits [14:1] of the absolute byte offset.

## Timing
- Reset values: `req_valid`=0, `req_offset`=0, `busy`=0, `done`=0, `rd_data`=0, `retry_cnt`=0, FSM=IDLE.
- `start` → `req_valid`=1: the next cycle.
- Handshake accept → RECV: the next cycle. A `resp_valid` arriving in that accept cycle is ignored.
- Odd byte → SPRAM write: the write is registered in the cycle after the `resp_valid` cycle (1-cycle latency).
- Back-to-back `resp_valid` must be accepted every cycle.
- Last byte of a chunk → `req_valid` for the next chunk: 1 cycle, or `done` after 1 cycle for the final chunk.
- Read port: `rd_addr` sampled at cycle N gives `rd_data` valid at cycle N+1.
- Reset mid-load: all state clears immediately; SPRAM contents are undefined and a new `start` is required.

## Configuration
- `FREAD_LOADER_RETRY_EN` defined:
  - In RECV, a counter of cycles since the last byte (or since handshake accept) runs.
  - On reaching `TIMEOUT_CYC`, clear the byte counter, keep the chunk offset, return to REQ, and increment `retry_cnt` (saturating at 255).
  - Retries are unlimited.
- `FREAD_LOADER_RETRY_EN` undefined:
  - No timeout counter exists; RECV waits indefinitely.
  - `retry_cnt` is tied to 0.

## Structure
- Shared package `fread_loader_pkg` holds:
  - the FSM state enum;
  - `SPRAM_WORDS`=16384 and the 14-bit address width;
  - an elaboration check that `TOTAL_LEN % CHUNK_LEN == 0` and `CHUNK_LEN` is even.
- One sub-module: `spram_16k`.
  - Wraps an `SB_SPRAM256KA`: 14-bit address, 16-bit data, single port, mask write enable 4'b1111.
  - The loader muxes the write path and the read path onto it based on `busy`.

## Test plan
- Reset, then `start`; the model answers each request after 3 cycles of `req_ready` with 2048 bytes where byte *i* = *i*[7:0].
  - Expect requests at offsets 0x0000, 0x0800 … 0x7800 (16 requests).
  - Expect `done`=1 after the 32768th byte.
  - Expect `rd_addr`=0 → `rd_data`=16'h0100 and `rd_addr`=0x3FFF → `rd_data`=16'hFFFE.
- `resp_valid` pulses while in REQ and during the accept cycle → no SPRAM write and no counter change; the final image matches the golden model.
- `start` pulses during a load → ignored; exactly 16 requests are issued.
- With `FREAD_LOADER_RETRY_EN` and `TIMEOUT_CYC`=64: the model drops the stream after 100 bytes of chunk 3.
  - Expect a re-request at offset 0x1800 and `retry_cnt`=1.
  - The image must be correct.
- `rst_n` asserted mid-chunk 5 → next cycle all outputs at reset values; `start` restarts at offset 0.
- In DONE, `start` → `done` falls, `req_offset` returns to 0, and the reload completes.
